// File: rtl/pc_stack_unit_if.sv
// Sequencing request/response bundle between the instruction controller (master) and the PC/return-stack unit (slave).
interface pc_stack_unit_if #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8,
  parameter int OFF_W  = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              enablePC;
  logic [1:0]        selectAdress;
  logic              push;
  logic              pop;
  logic              RET;
  logic [ADDR_W-1:0] Adress;
  logic [OFF_W-1:0]  branchOffset;

  logic [ADDR_W-1:0] PC;
  logic [ADDR_W-1:0] stackTop;
  logic [CNT_W-1:0]  stackCount;
  logic              stackFull;
  logic              stackEmpty;
  logic              overflow;
  logic              underflow;

  modport master (
    output enablePC, selectAdress, push, pop, RET, Adress, branchOffset,
    input  PC, stackTop, stackCount, stackFull, stackEmpty, overflow, underflow
  );

  modport slave (
    input  enablePC, selectAdress, push, pop, RET, Adress, branchOffset,
    output PC, stackTop, stackCount, stackFull, stackEmpty, overflow, underflow
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Program-counter sequencer with a LIFO return-address stack; PC/stack update one cycle after a request.
// No backpressure: enablePC low freezes all state, sticky overflow/underflow never stall sequencing.
module pc_stack_unit #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8,
  parameter int OFF_W  = 8
) (
  input logic           clock,
  input logic           reset,
  pc_stack_unit_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;
  logic              r_unf;
  logic [ADDR_W-1:0] r_mem [DEPTH];

  logic              w_full;
  logic              w_empty;
  logic [PTR_W-1:0]  w_top_idx;
  logic [PTR_W-1:0]  w_wr_idx;
  logic [ADDR_W-1:0] w_top;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_off_ext;
  logic [ADDR_W-1:0] w_br_target;
  logic              w_jump;
  logic              w_call_wr;

  assign w_full      = (r_cnt == CNT_W'(DEPTH));
  assign w_empty     = (r_cnt == '0);
  assign w_top_idx   = PTR_W'(r_cnt - CNT_W'(1));
  assign w_wr_idx    = r_cnt[PTR_W-1:0];
  assign w_top       = w_empty ? '0 : r_mem[w_top_idx];
  assign w_pc_inc    = r_pc + ADDR_W'(1);
  assign w_off_ext   = ADDR_W'($signed(bus.branchOffset));
  assign w_br_target = w_pc_inc + w_off_ext;

  // A pop in the same cycle suppresses any jump and therefore any push.
  assign w_jump    = bus.enablePC && !bus.pop && (bus.selectAdress == 2'b10);
  assign w_call_wr = !reset && w_jump && bus.push && !w_full;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (bus.enablePC) begin
      if (bus.pop) begin
        if (w_empty) begin
          r_unf <= 1'b1;
          r_pc  <= w_pc_inc;
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
          r_pc  <= bus.RET ? w_top : w_pc_inc;
        end
      end else begin
        unique case (bus.selectAdress)
          2'b10: begin
            r_pc <= bus.Adress;
            if (bus.push) begin
              if (w_full) r_ovf <= 1'b1;
              else        r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          2'b01:   r_pc <= w_br_target;
          default: r_pc <= w_pc_inc;
        endcase
      end
    end
  end

  // Stack RAM needs no reset: entries above the count are unreachable.
  always_ff @(posedge clock) begin
    if (w_call_wr) r_mem[w_wr_idx] <= w_pc_inc;
  end

  assign bus.PC         = r_pc;
  assign bus.stackTop   = w_top;
  assign bus.stackCount = r_cnt;
  assign bus.stackFull  = w_full;
  assign bus.stackEmpty = w_empty;
  assign bus.overflow   = r_ovf;
  assign bus.underflow  = r_unf;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: stimulus queues expected post-edge state, a negedge monitor checks it.
module tb_pc_stack_unit;
  logic clock;
  logic reset;

  pc_stack_unit_if #(.ADDR_W(12), .DEPTH(8), .OFF_W(8)) bus ();

  pc_stack_unit #(.ADDR_W(12), .DEPTH(8), .OFF_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [11:0] pc;
    logic [3:0]  cnt;
    logic [11:0] top;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (bus.PC !== e.pc || bus.stackCount !== e.cnt || bus.stackTop !== e.top ||
          bus.stackFull !== e.full || bus.stackEmpty !== e.empty ||
          bus.overflow !== e.ovf || bus.underflow !== e.unf) begin
        bad++;
        $display("FAIL %s: got pc=%h cnt=%0d top=%h full=%b empty=%b ovf=%b unf=%b, want pc=%h cnt=%0d top=%h full=%b empty=%b ovf=%b unf=%b",
                 e.name, bus.PC, bus.stackCount, bus.stackTop, bus.stackFull, bus.stackEmpty,
                 bus.overflow, bus.underflow, e.pc, e.cnt, e.top, e.full, e.empty, e.ovf, e.unf);
      end
    end
  end

  task automatic step(input logic rs, input logic en, input logic [1:0] sel,
                      input logic ps, input logic pp, input logic rt,
                      input logic [11:0] adr, input logic [7:0] off, input string nm,
                      input logic [11:0] epc, input int ecnt, input logic [11:0] etop,
                      input logic eovf, input logic eunf);
    exp_t e;
    @(negedge clock);
    reset            = rs;
    bus.enablePC     = en;
    bus.selectAdress = sel;
    bus.push         = ps;
    bus.pop          = pp;
    bus.RET          = rt;
    bus.Adress       = adr;
    bus.branchOffset = off;
    @(posedge clock);
    #1;
    e.name  = nm;
    e.pc    = epc;
    e.cnt   = 4'(ecnt);
    e.top   = etop;
    e.full  = (ecnt == 8);
    e.empty = (ecnt == 0);
    e.ovf   = eovf;
    e.unf   = eunf;
    exp_q.push_back(e);
  endtask

  logic [11:0] ent [8];
  logic [11:0] tgt;
  logic [11:0] etop;

  initial begin
    reset = 1'b1;
    bus.enablePC = 1'b0; bus.selectAdress = 2'b00; bus.push = 1'b0; bus.pop = 1'b0;
    bus.RET = 1'b0; bus.Adress = '0; bus.branchOffset = '0;

    //   rs en sel    ps pp rt adr     off    name           pc      cnt top     ovf unf
    step(1, 0, 2'b00, 0, 0, 0, 12'h0,  8'h0,  "reset",       12'h000, 0, 12'h000, 0, 0);
    for (int i = 1; i <= 5; i++)
      step(0, 1, 2'b00, 0, 0, 0, 12'h0, 8'h0, "seq", 12'(i), 0, 12'h000, 0, 0);
    step(0, 1, 2'b10, 0, 0, 0, 12'h010, 8'h0,  "jmp010",     12'h010, 0, 12'h000, 0, 0);
    step(0, 1, 2'b01, 0, 0, 0, 12'h0,   8'hFE, "br_neg2",    12'h00F, 0, 12'h000, 0, 0);
    step(0, 1, 2'b01, 0, 0, 0, 12'h0,   8'h7F, "br_pos7f",   12'h08F, 0, 12'h000, 0, 0);
    step(0, 1, 2'b10, 0, 0, 0, 12'hFFF, 8'h0,  "jmpfff",     12'hFFF, 0, 12'h000, 0, 0);
    step(0, 1, 2'b00, 0, 0, 0, 12'h0,   8'h0,  "pc_wrap",    12'h000, 0, 12'h000, 0, 0);
    step(0, 1, 2'b10, 0, 0, 0, 12'h020, 8'h0,  "jmp020",     12'h020, 0, 12'h000, 0, 0);
    step(0, 1, 2'b10, 1, 0, 0, 12'h300, 8'h0,  "call300",    12'h300, 1, 12'h021, 0, 0);
    step(0, 1, 2'b00, 0, 1, 1, 12'h0,   8'h0,  "ret021",     12'h021, 0, 12'h000, 0, 0);

    // Nested calls from PC=0x021: entry 0 = 0x022, entry k = previous target + 1.
    ent[0] = 12'h022;
    for (int k = 1; k < 8; k++) ent[k] = 12'(12'h100 + (k - 1) * 16 + 1);
    for (int k = 0; k < 8; k++) begin
      tgt = 12'(12'h100 + k * 16);
      step(0, 1, 2'b10, 1, 0, 0, tgt, 8'h0, "nest_call", tgt, k + 1, ent[k], 0, 0);
    end
    step(0, 1, 2'b10, 1, 0, 0, 12'h200, 8'h0, "call_ovf",   12'h200, 8, 12'h161, 1, 0);
    for (int j = 1; j <= 8; j++) begin
      if (j == 8) etop = 12'h000;
      else        etop = ent[7 - j];
      step(0, 1, 2'b00, 0, 1, 1, 12'h0, 8'h0, "nest_ret", ent[8 - j], 8 - j, etop, 1, 0);
    end

    step(1, 0, 2'b00, 0, 0, 0, 12'h0,   8'h0,  "reset2",     12'h000, 0, 12'h000, 0, 0);
    step(0, 1, 2'b10, 0, 0, 0, 12'h040, 8'h0,  "jmp040",     12'h040, 0, 12'h000, 0, 0);
    step(0, 1, 2'b00, 0, 1, 1, 12'h0,   8'h0,  "ret_empty",  12'h041, 0, 12'h000, 0, 1);
    step(0, 1, 2'b00, 0, 0, 0, 12'h0,   8'h0,  "unf_sticky", 12'h042, 0, 12'h000, 0, 1);
    step(0, 1, 2'b00, 0, 1, 0, 12'h0,   8'h0,  "pop_empty",  12'h043, 0, 12'h000, 0, 1);
    step(0, 0, 2'b10, 1, 0, 0, 12'h555, 8'h0,  "hold",       12'h043, 0, 12'h000, 0, 1);
    step(0, 1, 2'b10, 1, 0, 0, 12'h500, 8'h0,  "call500",    12'h500, 1, 12'h044, 0, 1);
    step(0, 1, 2'b10, 1, 0, 0, 12'h600, 8'h0,  "call600",    12'h600, 2, 12'h501, 0, 1);
    step(0, 1, 2'b10, 1, 1, 1, 12'h777, 8'h0,  "push_pop",   12'h501, 1, 12'h044, 0, 1);
    step(0, 1, 2'b00, 0, 1, 0, 12'h0,   8'h0,  "pop_disc",   12'h502, 0, 12'h000, 0, 1);
    step(0, 1, 2'b10, 0, 0, 0, 12'hFFF, 8'h0,  "jmpfff2",    12'hFFF, 0, 12'h000, 0, 1);
    step(0, 1, 2'b10, 1, 0, 0, 12'h010, 8'h0,  "call_wrap",  12'h010, 1, 12'h000, 0, 1);
    step(0, 1, 2'b00, 0, 0, 1, 12'h0,   8'h0,  "ret_nopop",  12'h011, 1, 12'h000, 0, 1);
    step(0, 1, 2'b01, 1, 0, 0, 12'h0,   8'h00, "push_br",    12'h012, 1, 12'h000, 0, 1);
    step(1, 1, 2'b10, 1, 0, 0, 12'h333, 8'h0,  "rst_push",   12'h000, 0, 12'h000, 0, 0);

    for (int n = 0; n < 10 && exp_q.size() > 0; n++) begin
      @(negedge clock);
      #1;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected responses left unchecked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Program-counter sequencer with a hardware return-address stack.
- Consumes the next-address select and push/pop/RET strobes that the instruction controller decodes, and produces the fetch address for instruction memory.
- Sits between the controller and instruction memory. It is the responder to the controller's sequencing requests: subroutine calls push a return address, returns pop it.

Parameters:
- ADDR_W, 12, program-counter and address width.
- DEPTH, 8, return-stack entries (power of 2, at least 2).
- OFF_W, 8, branch offset width (two's complement).

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- enablePC  in  1  advance enable; low = hold all state.
- selectAdress  in  2  next-PC select: 00 sequential, 01 relative branch, 10 absolute jump, 11 reserved.
- push  in  1  call: push return address (PC+1).
- pop  in  1  remove top stack entry.
- RET  in  1  return: load PC from top of stack (qualified by pop).
- Adress  in  ADDR_W  absolute jump target.
- branchOffset  in  OFF_W  signed relative offset.
- PC  out  ADDR_W  current fetch address (registered).
- stackTop  out  ADDR_W  value at top of stack; 0 when empty.
- stackCount  out  $clog2(DEPTH)+1  number of valid entries.
- stackFull  out  1  stackCount == DEPTH.
- stackEmpty  out  1  stackCount == 0.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous and active-high, named reset.
  - Clock is named clock.
  - Reset has priority over every other input.
- Reset values: PC=0, stackCount=0, overflow=0, underflow=0. Hence stackEmpty=1, stackFull=0, stackTop=0. Stack RAM contents are don't-care.
- Hold: when enablePC=0, nothing changes (PC, stack, counters, sticky flags). Strobes are ignored.
- Latency: all updates occur on the rising edge when enablePC=1. New PC is visible one cycle after the request.
- stackTop, stackFull, stackEmpty are combinational from stackCount and stack RAM.
- Next-PC priority, highest first, with enablePC=1:
  1. pop=1 and RET=1, stack non-empty: PC <= stackTop; stackCount decrements.
  2. pop=1 and RET=1, stack empty: underflow <= 1; PC <= PC+1; stackCount unchanged.
  3. pop=1 and RET=0: discard top (decrement if non-empty, else set underflow); PC <= PC+1.
  4. selectAdress=10: PC <= Adress. If push=1 also:
     - not full: mem[stackCount] <= PC+1; stackCount increments.
     - full: overflow <= 1; no write; count unchanged; jump still taken.
  5. selectAdress=01: PC <= PC + 1 + sign_extend(branchOffset), truncated to ADDR_W (wraps modulo 2^ADDR_W).
  6. selectAdress=00 or 11: PC <= PC+1, wrapping from 2^ADDR_W-1 to 0.
- Simultaneous strobes:
  - push and pop in the same cycle: pop wins, push is ignored, overflow unaffected.
  - push with selectAdress other than 10: ignored.
  - RET without pop: ignored (treated per selectAdress).
- Return address wraps: a call at PC=2^ADDR_W-1 pushes 0.
- Sticky flags:
  - overflow and underflow clear only on reset.
  - Setting them never blocks further operation.
- Reset mid-sequence: a reset coincident with any strobe discards the strobe. Previous stack contents become unreachable (count=0).

Test Plan:
- Reset then 5 cycles with enablePC=1, selectAdress=00 -> PC = 0,1,2,3,4,5; stackEmpty=1.
- PC=0x010, selectAdress=01, branchOffset=0xFE (-2) -> PC=0x00F. Then branchOffset=0x7F -> PC=0x08F. At PC=0xFFF with selectAdress=00 -> PC=0x000.
- PC=0x020, selectAdress=10, push=1, Adress=0x300 -> PC=0x300, stackTop=0x021, stackCount=1. Then pop=1, RET=1 -> PC=0x021, stackEmpty=1.
- 9 nested calls with DEPTH=8 -> after 8 calls stackFull=1. Ninth call: PC=its target, overflow=1, stackCount=8, stackTop unchanged. 8 returns restore the addresses in LIFO order.
- pop=1, RET=1 on empty stack at PC=0x040 -> PC=0x041, underflow=1, stackCount=0. The flag stays 1 until reset.
- Call pending with enablePC=0 -> no change in any output. push and pop together with count=2 -> count=1 and PC=old stackTop. Reset asserted together with push -> PC=0, count=0.
